// File: rtl/mcu0_mem_slave_if.sv
// Bus between the MCU initiator and the wait-state memory slave.
`timescale 1ns/1ps
interface mcu0_mem_slave_if #(
  parameter int AW = 12
);
  logic          req;
  logic          we;
  logic          size;
  logic [AW-1:0] addr;
  logic [15:0]   wdata;
  logic [15:0]   rdata;
  logic          ack;
  logic          busy;

  modport master (
    output req, we, size, addr, wdata,
    input  rdata, ack, busy
  );

  modport slave (
    input  req, we, size, addr, wdata,
    output rdata, ack, busy
  );
endinterface

// File: rtl/mcu0_mem_slave.sv
// Byte-addressed memory slave with big-endian word access and a fixed
// number of wait states between request acceptance and the ack pulse.
//
// state   | meaning
// ST_IDLE | ready; a request at the edge is latched and accepted
// ST_WAIT | counting wait states down in cnt; access fires when cnt==0
// ST_ACK  | one-cycle completion pulse, then back to idle
`timescale 1ns/1ps
module mcu0_mem_slave #(
  parameter int WAIT = 1,
  parameter int AW   = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  mcu0_mem_slave_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'((WAIT > 0) ? (WAIT - 1) : 0);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic          size_q;
  logic [15:0]   wdata_q;
  logic [15:0]   rdata_q, rdata_d;

  logic [7:0]    mem [0:(2**AW)-1];

  logic          accept;
  logic          do_access;
  logic [AW-1:0] acc_addr;
  logic [AW-1:0] acc_addr1;
  logic          acc_we;
  logic          acc_size;
  logic [15:0]   acc_wdata;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    do_access = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          accept = 1'b1;
          if (WAIT == 0) begin
            do_access = 1'b1;
            state_d   = ST_ACK;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          do_access = 1'b1;
          state_d   = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With zero wait states the access happens on the acceptance edge itself,
  // before the latches hold anything, so it must use the live bus values.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_addr  = bus.addr;
      acc_we    = bus.we;
      acc_size  = bus.size;
      acc_wdata = bus.wdata;
    end else begin
      acc_addr  = addr_q;
      acc_we    = we_q;
      acc_size  = size_q;
      acc_wdata = wdata_q;
    end
    acc_addr1 = acc_addr + AW'(1);
  end

  always_comb begin
    rdata_d = rdata_q;
    if (do_access && !acc_we) begin
      if (acc_size) rdata_d = {mem[acc_addr], mem[acc_addr1]};
      else          rdata_d = {8'h00, mem[acc_addr]};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n && accept) begin
      addr_q  <= bus.addr;
      we_q    <= bus.we;
      size_q  <= bus.size;
      wdata_q <= bus.wdata;
    end
  end

  // Memory is deliberately not reset; reset only suppresses a pending write.
  always_ff @(posedge clock) begin
    if (reset_n && do_access && acc_we) begin
      if (acc_size) begin
        mem[acc_addr]  <= acc_wdata[15:8];
        mem[acc_addr1] <= acc_wdata[7:0];
      end else begin
        mem[acc_addr]  <= acc_wdata[7:0];
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = (state_q == ST_ACK);
  assign bus.busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mcu0_mem_slave.sv
// Scoreboard bench: three slaves (WAIT=1, 3, 0) driven one at a time by
// directed accesses; a negedge monitor pops expected rdata on every ack.
`timescale 1ns/1ps
module tb_mcu0_mem_slave;

  localparam int AW = 12;

  typedef struct packed {
    logic [1:0]  inst;
    logic [15:0] rd;
  } exp_t;

  logic          clock;
  logic          rst_v   [3];
  logic          req_v   [3];
  logic          we_v    [3];
  logic          size_v  [3];
  logic [AW-1:0] addr_v  [3];
  logic [15:0]   wdata_v [3];
  logic [15:0]   rdata_v [3];
  logic          ack_v   [3];
  logic          busy_v  [3];
  logic [15:0]   last_rd [3];

  exp_t exp_q[$];
  int   n_pass;
  int   n_total;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
    mcu0_mem_slave_if #(.AW(AW)) bus ();
    assign bus.req   = req_v[g];
    assign bus.we    = we_v[g];
    assign bus.size  = size_v[g];
    assign bus.addr  = addr_v[g];
    assign bus.wdata = wdata_v[g];
    assign rdata_v[g] = bus.rdata;
    assign ack_v[g]   = bus.ack;
    assign busy_v[g]  = bus.busy;
    mcu0_mem_slave #(.WAIT(WS), .AW(AW)) u_dut (
      .clock   (clock),
      .reset_n (rst_v[g]),
      .bus     (bus.slave)
    );
  end

  function automatic int wait_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 3 : 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clock) begin
    exp_t e;
    for (int g = 0; g < 3; g++) begin
      if (ack_v[g] === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_ack: inst %0d acked with nothing outstanding at %0t", g, $time);
        end else begin
          e = exp_q.pop_front();
          check("ack_inst", 32'(g), 32'(e.inst));
          check("rdata", 32'(rdata_v[g]), 32'(e.rd));
        end
      end
    end
  end

  // Called just after a negedge; returns just after a negedge with the slave idle.
  // Inputs are scrambled right after acceptance to prove the latched copy is used.
  task automatic access(input int g, input bit w, input bit sz, input logic [AW-1:0] a,
                        input logic [15:0] d, input logic [15:0] exp_rd);
    int   n;
    exp_t e;
    if (!w) last_rd[g] = exp_rd;
    e.inst = 2'(g);
    e.rd   = last_rd[g];
    exp_q.push_back(e);
    req_v[g] = 1'b1; we_v[g] = w; size_v[g] = sz; addr_v[g] = a; wdata_v[g] = d;
    @(posedge clock);
    @(negedge clock);
    req_v[g] = 1'b0; we_v[g] = ~w; size_v[g] = ~sz;
    addr_v[g] = a ^ 12'h5A5; wdata_v[g] = ~d;
    check("busy_during", 32'(busy_v[g]), 32'd1);
    n = 1;
    while (ack_v[g] !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("ack_latency", 32'(n), 32'(wait_of(g) + 1));
    @(negedge clock);
    check("busy_idle", 32'(busy_v[g]), 32'd0);
    check("ack_idle", 32'(ack_v[g]), 32'd0);
  endtask

  initial begin
    int acks;
    exp_t e;
    n_pass  = 0;
    n_total = 0;
    for (int g = 0; g < 3; g++) begin
      rst_v[g] = 1'b0; req_v[g] = 1'b0; we_v[g] = 1'b0; size_v[g] = 1'b0;
      addr_v[g] = '0; wdata_v[g] = 16'h0000; last_rd[g] = 16'h0000;
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    for (int g = 0; g < 3; g++) begin
      check("rst_ack", 32'(ack_v[g]), 32'd0);
      check("rst_busy", 32'(busy_v[g]), 32'd0);
      check("rst_rdata", 32'(rdata_v[g]), 32'd0);
      rst_v[g] = 1'b1;
    end

    // WAIT=1: basic reads/writes, endianness and address wrap
    access(0, 1, 0, 12'h010, 16'h0012, 16'h0000);
    access(0, 1, 0, 12'h011, 16'hAB34, 16'h0000);
    access(0, 0, 1, 12'h010, 16'h0000, 16'h1234);
    access(0, 1, 1, 12'h020, 16'hBEEF, 16'h0000);
    access(0, 0, 0, 12'h021, 16'h0000, 16'h00EF);
    access(0, 0, 1, 12'h020, 16'h0000, 16'hBEEF);
    access(0, 0, 0, 12'h020, 16'h0000, 16'h00BE);
    access(0, 1, 1, 12'hFFF, 16'hA55A, 16'h0000);
    access(0, 0, 0, 12'hFFF, 16'h0000, 16'h00A5);
    access(0, 0, 0, 12'h000, 16'h0000, 16'h005A);
    access(0, 0, 1, 12'hFFF, 16'h0000, 16'hA55A);
    access(0, 1, 0, 12'h011, 16'hCC77, 16'h0000);
    access(0, 0, 1, 12'h010, 16'h0000, 16'h1277);

    // WAIT=3: reset during the wait phase aborts the write
    access(1, 1, 1, 12'h040, 16'h0000, 16'h0000);
    access(1, 1, 1, 12'h050, 16'hCAFE, 16'h0000);
    access(1, 0, 1, 12'h050, 16'h0000, 16'hCAFE);
    req_v[1] = 1'b1; we_v[1] = 1'b1; size_v[1] = 1'b1;
    addr_v[1] = 12'h040; wdata_v[1] = 16'h1111;
    @(posedge clock);
    @(negedge clock);
    req_v[1] = 1'b0;
    @(posedge clock);
    @(negedge clock);
    rst_v[1] = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("midwait_busy", 32'(busy_v[1]), 32'd0);
    check("midwait_ack", 32'(ack_v[1]), 32'd0);
    check("midwait_rdata", 32'(rdata_v[1]), 32'd0);
    @(posedge clock);
    @(negedge clock);
    rst_v[1] = 1'b1;
    last_rd[1] = 16'h0000;
    access(1, 0, 1, 12'h040, 16'h0000, 16'h0000);
    access(1, 0, 1, 12'h050, 16'h0000, 16'hCAFE);

    // WAIT=0: single-edge access, then req held high for six cycles
    access(2, 1, 1, 12'h100, 16'h5AA5, 16'h0000);
    access(2, 0, 0, 12'h101, 16'h0000, 16'h00A5);
    e.inst = 2'd2;
    e.rd   = 16'h5AA5;
    repeat (3) exp_q.push_back(e);
    last_rd[2] = 16'h5AA5;
    req_v[2] = 1'b1; we_v[2] = 1'b0; size_v[2] = 1'b1; addr_v[2] = 12'h100;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (ack_v[2] === 1'b1) acks++;
      check("held_busy", 32'(busy_v[2]), 32'((i % 2) == 0));
    end
    req_v[2] = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (ack_v[2] === 1'b1) acks++;
    end
    check("held_ack_count", 32'(acks), 32'd3);

    repeat (5) @(negedge clock);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed so far", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mcu0_mem_slave.md
MCU0_MEM_SLAVE -- requirements
Module: mcu0_mem_slave

Interface
REQ-001 SHALL have parameter WAIT, default 1, meaning wait-state cycles inserted per access (legal range 0..15).
REQ-002 SHALL have parameter AW, default 12, meaning byte-address width; memory depth is 2**AW bytes.
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset, sampled on rising clock.
REQ-005 SHALL have port req  input  1  access request from the MCU initiator.
REQ-006 SHALL have port we  input  1  1 = write (ST), 0 = read (fetch, LD, ADD, CMP operand).
REQ-007 SHALL have port size  input  1  1 = 16-bit word, 0 = single byte.
REQ-008 SHALL have port addr  input  AW  byte address of the access.
REQ-009 SHALL have port wdata  input  16  write data; the byte write uses wdata[7:0].
REQ-010 SHALL have port rdata  output  16  read data, valid while ack=1.
REQ-011 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-012 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL hold a byte array mem[0:2**AW-1]; words are big-endian: word(a) = {mem[a], mem[a+1]}.
REQ-014 SHALL compute the second byte address as (a+1) mod 2**AW, so a word at 0xFFF uses mem[0xFFF] and mem[0x000].
REQ-015 SHALL implement FSM states IDLE, WAIT and ACK, with a 4-bit down-counter cnt.
REQ-016 SHALL, in IDLE with req=1 at a rising edge, latch addr, we, size and wdata into internal registers; later changes on these inputs SHALL be ignored until the next acceptance.
REQ-017 SHALL, on acceptance, go to WAIT with cnt=WAIT-1 when WAIT>0, or perform the access and go to ACK when WAIT=0.
REQ-018 SHALL, in WAIT, decrement cnt at each edge; at the edge where cnt==0 it SHALL perform the access and go to ACK.
REQ-019 SHALL perform each access at a single edge, using the latched values:
- word read: rdata <= word(a).
- byte read: rdata <= {8'h00, mem[a]}.
- word write: mem[a] <= wdata[15:8], mem[a+1] <= wdata[7:0].
- byte write: mem[a] <= wdata[7:0].
REQ-020 SHALL leave rdata unchanged on writes.
REQ-021 SHALL assert ack=1 for exactly the one cycle spent in ACK, then return to IDLE unconditionally.
REQ-022 SHALL make ack go high WAIT+1 cycles after the acceptance edge.
REQ-023 SHALL ignore req during WAIT and ACK; a new request is accepted only in IDLE, so the minimum back-to-back period is WAIT+2 cycles.
REQ-024 SHALL NOT assume req is dropped after ack; if req is still 1 in the IDLE cycle after ACK, it is a new request and SHALL be accepted.
REQ-025 SHALL hold rdata from the last read until the next read completes.
REQ-026 SHALL drive busy = (state != IDLE), registered-state based, with no combinational path from req.

Reset
REQ-027 SHALL, when reset_n=0 at a rising edge, set state=IDLE, cnt=0, ack=0 and rdata=16'h0000.
REQ-028 SHALL NOT clear the memory array on reset; mem contents persist across reset.
REQ-029 SHALL abort an access on reset asserted in WAIT, with no memory write and no ack.
REQ-030 SHALL give reset priority over an access scheduled at the same edge.
REQ-031 SHALL accept a request at the first edge with reset_n=1.

Verification
REQ-032 SHALL cover word read: WAIT=1, preload mem[0x010]=0x12, mem[0x011]=0x34; word read 0x010 -> ack in the 2nd cycle after acceptance, rdata=0x1234.
REQ-033 SHALL cover word write then byte read: write 0xBEEF to 0x020, then byte read 0x021 -> rdata=0x00EF; word read 0x020 -> 0xBEEF.
REQ-034 SHALL cover the wrap boundary: word write 0xA55A at 0xFFF -> mem[0xFFF]=0xA5 and mem[0x000]=0x5A; word read 0xFFF returns 0xA55A.
REQ-035 SHALL cover reset mid-WAIT: WAIT=3, word write 0x1111 to 0x040 (old 0x0000), reset_n=0 during cnt=1 -> no ack, mem[0x040..0x041] still 0x0000, rdata=0x0000, busy=0.
REQ-036 SHALL cover held req: WAIT=0, req held high 6 cycles on a read -> exactly 3 ack pulses, every other cycle, busy toggling 1/0.
REQ-037 SHALL cover input change after acceptance: change addr during WAIT -> access uses the latched addr.
